// File: rtl/cpu_if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited word reads and
// buffers each returned word with its PC for decode; redirects flush and discard.
module cpu_if_stage #(
  parameter logic [31:0] INITIAL_PC = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = 8;
  localparam logic [CW:0]   DEPTH_W    = (CW+1)'(FIFO_DEPTH);
  localparam logic [DW-1:0] DISC_LIMIT = DW'(255 - FIFO_DEPTH);

  logic [31:0]   pc_q;
  logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]   fifo_instr_q [FIFO_DEPTH];
  logic [AW-1:0] fifo_rd_q, fifo_wr_q;
  logic [CW-1:0] fifo_cnt_q;
  logic [31:0]   pend_pc_q    [FIFO_DEPTH];
  logic [AW-1:0] pend_rd_q, pend_wr_q;
  logic [CW-1:0] live_q;
  logic [DW-1:0] discard_q;

  logic [CW:0] in_use;
  logic        grant;
  logic        rsp_live;
  logic        pop;

  // Only live (non-discarded) requests consume credit; the pending queue holds just
  // their PCs, since discarded responses are always older and are dropped by count.
  assign in_use     = {1'b0, fifo_cnt_q} + {1'b0, live_q};
  assign imem_req_o = !rst_i && !redirect_i && (in_use < DEPTH_W) && (discard_q <= DISC_LIMIT);
  assign imem_addr_o = pc_q;
  assign grant      = imem_req_o && imem_gnt_i;
  assign rsp_live   = imem_rvalid_i && (discard_q == '0);
  assign pop        = instr_valid_o && instr_ready_i;

  assign instr_valid_o = (fifo_cnt_q != '0);
  assign instr_o       = fifo_instr_q[fifo_rd_q];
  assign instr_pc_o    = fifo_pc_q[fifo_rd_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= INITIAL_PC;
    end else if (redirect_i) begin
      pc_q <= {redirect_pc_i[31:2], 2'b00};
    end else if (grant) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) pend_pc_q[i] <= '0;
      pend_rd_q <= '0;
      pend_wr_q <= '0;
      live_q    <= '0;
    end else if (redirect_i) begin
      pend_rd_q <= pend_wr_q;
      live_q    <= '0;
    end else begin
      if (grant) begin
        pend_pc_q[pend_wr_q] <= pc_q;
        pend_wr_q            <= pend_wr_q + AW'(1);
      end
      if (rsp_live) pend_rd_q <= pend_rd_q + AW'(1);
      case ({grant, rsp_live})
        2'b10:   live_q <= live_q + CW'(1);
        2'b01:   live_q <= live_q - CW'(1);
        default: live_q <= live_q;
      endcase
    end
  end

  // A redirect turns every request still in flight into one to be dropped, less the
  // one (discarded or live) that returns in the redirect cycle itself.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      discard_q <= '0;
    end else if (redirect_i) begin
      discard_q <= discard_q + DW'(live_q) - DW'(imem_rvalid_i);
    end else if (imem_rvalid_i && (discard_q != '0)) begin
      discard_q <= discard_q - DW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
      fifo_cnt_q <= '0;
    end else if (redirect_i) begin
      fifo_rd_q  <= fifo_wr_q;
      fifo_cnt_q <= '0;
    end else begin
      if (rsp_live) begin
        fifo_pc_q[fifo_wr_q]    <= pend_pc_q[pend_rd_q];
        fifo_instr_q[fifo_wr_q] <= imem_rdata_i;
        fifo_wr_q               <= fifo_wr_q + AW'(1);
      end
      if (pop) fifo_rd_q <= fifo_rd_q + AW'(1);
      case ({rsp_live, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_if_stage.sv
// Bench for cpu_if_stage: a latency-configurable instruction memory plus a
// transaction-level model of the expected fetch stream.
module tb_cpu_if_stage;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] INIT_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i = 1'b0;

  cpu_if_stage #(.INITIAL_PC(INIT_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int cycle = 0;
  always @(posedge clk_i) cycle <= cycle + 1;

  int tests_run = 0;
  int tests_failed = 0;

  // One entry per granted request, in grant order: what memory returns and what decode expects.
  typedef struct { logic [31:0] addr; logic [31:0] exp_pc; int due; bit live; } flight_t;
  flight_t     flight_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] model_pc = INIT_PC;

  int gnt_pct = 100;
  int lat_min = 0;
  int lat_max = 0;

  typedef struct { logic rdy; logic exp_valid; logic [31:0] exp_pc; } vec_t;
  vec_t t1_vec[6];

  typedef struct { int gnt_pct; int lat_max; int rdy_pct; int redir_pct; int cycles; } scen_t;
  scen_t scen[4];

  function automatic logic [31:0] memData(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic failTimeout(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: timed out waiting for instr_valid_o (cycle %0d)", name, cycle);
  endtask

  // Compares this cycle's outputs, then advances the model as the coming edge will.
  task automatic modelCycle();
    int      live;
    flight_t e;
    if (rst_i) begin
      checkOutput("rst_req", imem_req_o, 0);
      checkOutput("rst_valid", instr_valid_o, 0);
      checkOutput("rst_instr", instr_o, 0);
      checkOutput("rst_pc", instr_pc_o, 0);
      flight_q.delete();
      exp_q.delete();
      model_pc = INIT_PC;
      return;
    end
    live = 0;
    foreach (flight_q[i]) if (flight_q[i].live) live++;
    checkOutput("req", imem_req_o, (!redirect_i && (exp_q.size() + live < DEPTH)));
    if (imem_req_o) checkOutput("addr", imem_addr_o, model_pc);
    checkOutput("valid", instr_valid_o, (exp_q.size() != 0));
    if (instr_valid_o && exp_q.size() != 0) begin
      checkOutput("instr_pc", instr_pc_o, exp_q[0]);
      checkOutput("instr", instr_o, memData(exp_q[0]));
    end
    assert (!imem_rvalid_i || flight_q.size() > 0) else $error("[TB] rvalid without grant");

    if (!redirect_i && instr_valid_o && instr_ready_i && exp_q.size() != 0) void'(exp_q.pop_front());
    if (imem_rvalid_i && flight_q.size() != 0) begin
      e = flight_q.pop_front();
      if (e.live && !redirect_i) exp_q.push_back(e.exp_pc);
    end
    if (imem_req_o && imem_gnt_i) begin
      flight_q.push_back('{imem_addr_o, model_pc, cycle + 1 + $urandom_range(lat_max, lat_min), !redirect_i});
      if (!redirect_i) model_pc = model_pc + 32'd4;
    end
    if (redirect_i) begin
      foreach (flight_q[i]) flight_q[i].live = 1'b0;
      exp_q.delete();
      model_pc = redirect_pc_i & ~32'h3;
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic redir, input logic [31:0] tgt, input logic rdy);
    @(posedge clk_i);
    #1;
    rst_i         = rst;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    instr_ready_i = rdy;
    imem_gnt_i    = ($urandom_range(99, 0) < gnt_pct);
    if (flight_q.size() != 0 && flight_q[0].due <= cycle) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = memData(flight_q[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    @(negedge clk_i);
    modelCycle();
  endtask

  task automatic waitValid(input string name, input logic [31:0] exp_pc);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      applyStimulus(0, 0, 32'h0, 1);
      if (instr_valid_o) begin
        seen = 1;
        checkOutput({name, "_pc"}, instr_pc_o, exp_pc);
        checkOutput({name, "_instr"}, instr_o, memData(exp_pc));
      end
    end
    if (!seen) failTimeout(name);
  endtask

  task automatic runStartTable(input string name);
    gnt_pct = 100; lat_min = 0; lat_max = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 0, 32'h0, t1_vec[k].rdy);
      checkOutput({name, "_valid"}, instr_valid_o, t1_vec[k].exp_valid);
      if (t1_vec[k].exp_valid) checkOutput({name, "_pc"}, instr_pc_o, t1_vec[k].exp_pc);
    end
  endtask

  initial begin
    logic [31:0] a0;
    t1_vec[0] = '{1'b1, 1'b0, 32'h0};
    t1_vec[1] = '{1'b1, 1'b0, 32'h0};
    t1_vec[2] = '{1'b1, 1'b1, INIT_PC};
    t1_vec[3] = '{1'b1, 1'b1, INIT_PC + 32'h4};
    t1_vec[4] = '{1'b1, 1'b1, INIT_PC + 32'h8};
    t1_vec[5] = '{1'b1, 1'b1, INIT_PC + 32'hC};
    scen[0] = '{100, 0, 100, 0, 200};
    scen[1] = '{70, 3, 60, 5, 600};
    scen[2] = '{50, 4, 40, 20, 600};
    scen[3] = '{90, 2, 80, 40, 400};

    applyStimulus(1, 0, 32'h0, 1);
    applyStimulus(1, 0, 32'h0, 1);
    runStartTable("t1");

    // Decode stall fills the buffer and drops credit, then the stream resumes.
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 32'h0, 0);
    checkOutput("t2_req_low", imem_req_o, 0);
    checkOutput("t2_valid_held", instr_valid_o, 1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 32'h0, 1);

    // Ungranted request holds its address; the grant then steps it by 4.
    gnt_pct = 0;
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 32'h0, 1);
    checkOutput("t3_req_up", imem_req_o, 1);
    a0 = imem_addr_o;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 32'h0, 1);
      checkOutput("t3_addr_hold", imem_addr_o, a0);
    end
    gnt_pct = 100;
    applyStimulus(0, 0, 32'h0, 1);
    applyStimulus(0, 0, 32'h0, 1);
    checkOutput("t3_addr_step", imem_addr_o, a0 + 32'h4);

    // Redirect with two slow responses in flight.
    gnt_pct = 0;
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 32'h0, 1);
    gnt_pct = 100; lat_min = 5; lat_max = 5;
    applyStimulus(0, 0, 32'h0, 1);
    applyStimulus(0, 0, 32'h0, 1);
    gnt_pct = 0;
    applyStimulus(0, 1, 32'h0000_0100, 1);
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    waitValid("t4", 32'h0000_0100);

    // Redirect in a cycle with rvalid and pop both active.
    lat_min = 0; lat_max = 0;
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 32'h0, 1);
    applyStimulus(0, 1, 32'h0000_0203, 1);
    checkOutput("t5_valid_at_redirect", instr_valid_o, 1);
    applyStimulus(0, 0, 32'h0, 1);
    checkOutput("t5_flushed", instr_valid_o, 0);
    waitValid("t5", 32'h0000_0200);

    // Back-to-back redirects with outstanding responses: the second target wins.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 32'h0, 1);
    applyStimulus(0, 1, 32'h0000_0300, 1);
    applyStimulus(0, 1, 32'h0000_0400, 1);
    waitValid("t_b2b", 32'h0000_0400);

    // PC wraps from the top of the address space; low target bits are ignored.
    lat_min = 0; lat_max = 1;
    applyStimulus(0, 1, 32'hFFFF_FFF9, 1);
    waitValid("t_wrap", 32'hFFFF_FFF8);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 32'h0, 1);

    // Asynchronous reset mid-stream, then a clean restart.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 32'h0, 1);
    applyStimulus(1, 0, 32'h0, 1);
    applyStimulus(1, 0, 32'h0, 1);
    runStartTable("t6");

    for (int s = 0; s < 4; s++) begin
      gnt_pct = scen[s].gnt_pct; lat_min = 0; lat_max = scen[s].lat_max;
      for (int i = 0; i < scen[s].cycles; i++) begin
        applyStimulus(0, ($urandom_range(99, 0) < scen[s].redir_pct),
                      $urandom & 32'h0000_FFFF, ($urandom_range(99, 0) < scen[s].rdy_pct));
      end
      gnt_pct = 100;
      for (int i = 0; i < 12; i++) applyStimulus(0, 0, 32'h0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
